uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, one-entry output register; byte valid 1 clk after the stop sample.
// rx_valid holds until rx_ready; a byte completing while the register is full is dropped with an overrun pulse.
module uart_rx #(
  parameter int FREQ = 12500000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV_RAW = FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic          rx_meta_q;
  logic          rx_s_q;
  logic [CW-1:0] tcnt_q;
  logic          tick;

  state_e        state_q, state_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;

  logic          stop_ok;
  logic          stop_bad;

  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (tcnt_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (tick) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      scnt_q  <= 4'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (tick) begin
      scnt_d = scnt_q + 4'd1;
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            scnt_d  = 4'd0;
          end
        end
        S_START: begin
          // Mid start bit: a line already back high was a glitch.
          if (scnt_q == 4'd7) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              scnt_d  = 4'd0;
              idx_d   = 3'd0;
            end
          end
        end
        S_DATA: begin
          if (scnt_q == 4'd15) begin
            shift_d[idx_q] = rx_s_q;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = S_STOP;
              scnt_d  = 4'd0;
            end
          end
        end
        S_STOP: begin
          if (scnt_q == 4'd15) begin
            state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (tick && (state_q == S_STOP) && (scnt_q == 4'd15)) begin
      stop_ok  = rx_s_q;
      stop_bad = !rx_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (stop_ok) begin
        // A same-edge accept frees the register for the new byte.
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk per bit; expected bytes queued at send time, popped by a handshake monitor.
module tb_uart_rx;

  localparam int FREQ = 1600;
  localparam int BAUD = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.FREQ(FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int acc_cnt  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Scoreboard monitor: every accepted byte must match the oldest queued byte.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (frame_err === 1'b1 && overrun === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL exclusive_pulses: frame_err=1 and overrun=1 at cycle %0d, expected at most one", cyc);
    end
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h at cycle %0d, expected no byte", rx_data, cyc);
      end else begin
        check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
      end
      acc_cnt++;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_after);
    rx = 1'b0;
    fall_cyc = cyc;
    tick_n(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick_n(16);
    end
    rx = stop_bit;
    tick_n(16);
    if (low_after > 0) begin
      rx = 1'b0;
      tick_n(low_after);
    end
    rx = 1'b1;
  endtask

  task automatic wait_acc(input string name, input int n, input int budget);
    for (int i = 0; i < budget && acc_cnt < n; i++) @(negedge clk);
    check(name, acc_cnt, n);
  endtask

  int base_acc;
  int lat;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    tick_n(3);
    @(negedge clk);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle line
    tick_n(200);
    check("idle_no_byte", acc_cnt, 0);
    check("idle_no_ferr", ferr_cnt, 0);
    check("idle_no_ovr", ovr_cnt, 0);

    // 0xA5 with consumer ready: latency and one-cycle valid
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        int k;
        k = 0;
        while (rx_valid !== 1'b1 && k < 400) begin
          @(negedge clk);
          k++;
        end
        lat = cyc - fall_cyc;
        check("a5_latency_in_150_160", int'(lat >= 150 && lat <= 160), 1);
        check("a5_data_direct", int'(rx_data), 'hA5);
        @(negedge clk);
        check("a5_valid_drop", int'(rx_valid), 0);
      end
    join
    wait_acc("a5_accepted", 1, 50);
    check("a5_no_ferr", ferr_cnt, 0);

    // Short glitch rejected in START
    base_acc = acc_cnt;
    rx = 1'b0;
    tick_n(4);
    rx = 1'b1;
    tick_n(100);
    check("glitch_no_byte", acc_cnt, base_acc);
    check("glitch_no_ferr", ferr_cnt, 0);
    check("glitch_valid_low", int'(rx_valid), 0);

    // Bad stop bit then break: exactly one frame_err, then recovery
    send_frame(8'h3C, 1'b0, 100);
    tick_n(40);
    check("break_one_ferr", ferr_cnt, 1);
    check("break_no_byte", acc_cnt, base_acc);
    check("break_no_ovr", ovr_cnt, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 0);
    wait_acc("recover_55_accepted", base_acc + 1, 100);
    tick_n(10);

    // Overrun: second byte dropped while the first is held
    rx_ready = 1'b0;
    base_acc = acc_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0);
    tick_n(20);
    send_frame(8'h22, 1'b1, 0);
    tick_n(20);
    check("ovr_one_pulse", ovr_cnt, 1);
    check("ovr_valid_held", int'(rx_valid), 1);
    check("ovr_data_kept", int'(rx_data), 'h11);
    check("ovr_no_ferr", ferr_cnt, 1);
    rx_ready = 1'b1;
    tick_n(1);
    rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_cleared", int'(rx_valid), 0);
    check("ovr_one_accept", acc_cnt, base_acc + 1);
    tick_n(1);
    rx_ready = 1'b1;
    tick_n(10);

    // Reset in the middle of data bit 3 abandons the frame
    base_acc = acc_cnt;
    rx = 1'b0;
    tick_n(16);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      tick_n(16);
    end
    rx = 1'b0;
    tick_n(8);
    rst = 1'b1;
    rx  = 1'b1;
    tick_n(1);
    rst = 1'b0;
    tick_n(200);
    check("rst_mid_no_byte", acc_cnt, base_acc);
    check("rst_mid_no_ferr", ferr_cnt, 1);
    check("rst_mid_no_ovr", ovr_cnt, 1);
    check("rst_mid_valid_low", int'(rx_valid), 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 0);
    wait_acc("c3_accepted", base_acc + 1, 100);
    tick_n(10);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
